burst_memtest_logic: RTL and testbench



---
 rtl/burst_memtest_logic.sv | 182 ++++++++++++++++++
 tb/tb_burst_memtest_logic.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_memtest_logic.sv
// Burst memory-test sequencer: drives the Avalon write/read DMA masters with a
// seeded incrementing pattern and optionally verifies the read-back stream.
module burst_memtest_logic #(
    parameter int ADDRESSWIDTH    = 26,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int LENWIDTH        = 16,
    parameter int ERRWIDTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic                    fixed_loc,
    input  logic [ADDRESSWIDTH-1:0] base_address,
    input  logic [LENWIDTH-1:0]     num_words,
    input  logic [DATAWIDTH-1:0]    seed,
    output logic                    busy,
    output logic                    done,
    output logic [ERRWIDTH-1:0]     error_count,
    output logic [ADDRESSWIDTH-1:0] first_err_addr,
    output logic [DATAWIDTH-1:0]    last_read_data,
    input  logic                    write_control_done,
    output logic                    write_control_fixed_location,
    output logic [ADDRESSWIDTH-1:0] write_control_write_base,
    output logic [ADDRESSWIDTH-1:0] write_control_write_length,
    output logic                    write_control_go,
    output logic                    write_user_write_buffer,
    output logic [DATAWIDTH-1:0]    write_user_buffer_data,
    input  logic                    write_user_buffer_full,
    input  logic                    read_control_done,
    output logic                    read_control_fixed_location,
    output logic [ADDRESSWIDTH-1:0] read_control_read_base,
    output logic [ADDRESSWIDTH-1:0] read_control_read_length,
    output logic                    read_control_go,
    output logic                    read_user_read_buffer,
    input  logic [DATAWIDTH-1:0]    read_user_buffer_output_data,
    input  logic                    read_user_data_available
);

    localparam int ALIGN = $clog2(BYTEENABLEWIDTH);

    typedef enum logic [2:0] {
        IDLE, WR_GO, WR_FILL, WR_WAIT, RD_GO, RD_DRAIN, RD_WAIT, DONE
    } state_t;

    state_t                  r_state, w_next;
    logic                    r_wr_only, r_verify, r_fixed, r_err_seen;
    logic [ADDRESSWIDTH-1:0] r_base, r_length, r_first_err_addr;
    logic [LENWIDTH-1:0]     r_num_words, r_wr_cnt, r_rd_cnt;
    logic [DATAWIDTH-1:0]    r_seed, r_last_read;
    logic [ERRWIDTH-1:0]     r_err_cnt;

    logic                    w_busy, w_done, w_wr_go, w_rd_go, w_push, w_pop;
    logic                    w_wr_more, w_rd_more, w_mismatch;
    logic [DATAWIDTH-1:0]    w_exp_rd;

    assign w_wr_more  = r_wr_cnt < r_num_words;
    assign w_rd_more  = r_rd_cnt < r_num_words;
    assign w_exp_rd   = r_seed + DATAWIDTH'(r_rd_cnt);
    assign w_mismatch = read_user_buffer_output_data != w_exp_rd;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_wr_go = 1'b0;
        w_rd_go = 1'b0;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (num_words == '0)    w_next = DONE;
                    else if (mode == 2'd1)  w_next = RD_GO;
                    else                    w_next = WR_GO;
                end
            end
            WR_GO: begin
                w_busy  = 1'b1;
                w_wr_go = 1'b1;
                w_next  = WR_FILL;
            end
            WR_FILL: begin
                w_busy = 1'b1;
                w_push = !write_user_buffer_full && w_wr_more;
                if (!w_wr_more) w_next = WR_WAIT;
            end
            WR_WAIT: begin
                w_busy = 1'b1;
                if (write_control_done) w_next = r_wr_only ? DONE : RD_GO;
            end
            RD_GO: begin
                w_busy  = 1'b1;
                w_rd_go = 1'b1;
                w_next  = RD_DRAIN;
            end
            RD_DRAIN: begin
                w_busy = 1'b1;
                w_pop  = read_user_data_available && w_rd_more;
                // an early read_control_done is deliberately not looked at here
                if (!w_rd_more) w_next = RD_WAIT;
            end
            RD_WAIT: begin
                w_busy = 1'b1;
                if (read_control_done) w_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_only        <= 1'b0;
            r_verify         <= 1'b0;
            r_fixed          <= 1'b0;
            r_err_seen       <= 1'b0;
            r_base           <= '0;
            r_length         <= '0;
            r_first_err_addr <= '0;
            r_num_words      <= '0;
            r_wr_cnt         <= '0;
            r_rd_cnt         <= '0;
            r_seed           <= '0;
            r_last_read      <= DATAWIDTH'(32'hFEEDFEED);
            r_err_cnt        <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_wr_only   <= (mode == 2'd0);
                r_verify    <= mode[1];
                r_fixed     <= fixed_loc;
                r_base      <= base_address & ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
                r_length    <= ADDRESSWIDTH'(num_words) << ALIGN;
                r_num_words <= num_words;
                r_seed      <= seed;
                r_wr_cnt    <= '0;
                r_rd_cnt    <= '0;
                r_err_cnt   <= '0;
                r_err_seen  <= 1'b0;
            end
            if (w_push) r_wr_cnt <= r_wr_cnt + LENWIDTH'(1);
            if (w_pop) begin
                r_last_read <= read_user_buffer_output_data;
                r_rd_cnt    <= r_rd_cnt + LENWIDTH'(1);
                if (r_verify && w_mismatch) begin
                    if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERRWIDTH'(1);
                    if (!r_err_seen) begin
                        r_err_seen       <= 1'b1;
                        r_first_err_addr <= r_base + (ADDRESSWIDTH'(r_rd_cnt) << ALIGN);
                    end
                end
            end
        end
    end

    assign busy                         = w_busy;
    assign done                         = w_done;
    assign error_count                  = r_err_cnt;
    assign first_err_addr               = r_first_err_addr;
    assign last_read_data               = r_last_read;
    assign write_control_fixed_location = r_fixed;
    assign write_control_write_base     = r_base;
    assign write_control_write_length   = r_length;
    assign write_control_go             = w_wr_go;
    assign write_user_write_buffer      = w_push;
    assign write_user_buffer_data       = r_seed + DATAWIDTH'(r_wr_cnt);
    assign read_control_fixed_location  = r_fixed;
    assign read_control_read_base       = r_base;
    assign read_control_read_length     = r_length;
    assign read_control_go              = w_rd_go;
    assign read_user_read_buffer        = w_pop;

endmodule

// File: tb/tb_burst_memtest_logic.sv
// Bench for burst_memtest_logic: behavioural write/read masters over a small
// memory, with queues of expected pushed and popped words.
module tb_burst_memtest_logic;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset, start, fixed_loc;
    logic [1:0]    mode;
    logic [AW-1:0] base_address;
    logic [LW-1:0] num_words;
    logic [DW-1:0] seed;
    logic          busy, done;
    logic [EW-1:0] error_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] last_read_data;
    logic          write_control_done, write_control_fixed_location, write_control_go;
    logic [AW-1:0] write_control_write_base, write_control_write_length;
    logic          write_user_write_buffer, write_user_buffer_full;
    logic [DW-1:0] write_user_buffer_data;
    logic          read_control_done, read_control_fixed_location, read_control_go;
    logic [AW-1:0] read_control_read_base, read_control_read_length;
    logic          read_user_read_buffer, read_user_data_available;
    logic [DW-1:0] read_user_buffer_output_data;

    always #5 clk = ~clk;

    burst_memtest_logic #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(4),
                          .LENWIDTH(LW), .ERRWIDTH(EW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .fixed_loc(fixed_loc),
        .base_address(base_address), .num_words(num_words), .seed(seed),
        .busy(busy), .done(done), .error_count(error_count),
        .first_err_addr(first_err_addr), .last_read_data(last_read_data),
        .write_control_done(write_control_done),
        .write_control_fixed_location(write_control_fixed_location),
        .write_control_write_base(write_control_write_base),
        .write_control_write_length(write_control_write_length),
        .write_control_go(write_control_go),
        .write_user_write_buffer(write_user_write_buffer),
        .write_user_buffer_data(write_user_buffer_data),
        .write_user_buffer_full(write_user_buffer_full),
        .read_control_done(read_control_done),
        .read_control_fixed_location(read_control_fixed_location),
        .read_control_read_base(read_control_read_base),
        .read_control_read_length(read_control_read_length),
        .read_control_go(read_control_go),
        .read_user_read_buffer(read_user_read_buffer),
        .read_user_buffer_output_data(read_user_buffer_output_data),
        .read_user_data_available(read_user_data_available)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] exp_wr_q [$];
    logic [31:0] exp_rd_q [$];
    logic [31:0] rd_fifo [$];

    int wr_go_cnt = 0, rd_go_cnt = 0, push_cnt = 0, pop_cnt = 0, done_cnt = 0;
    int full_cycles = 0, wr_words = 0, wr_pushes = 0, wr_done_dly = 0, rd_done_dly = 0;
    int stall_at = 0, stall_left = 0, corrupt_pos = -1, cyc = 0;
    bit avail_toggle = 1'b0, pop_pending = 1'b0;
    logic [31:0] pop_exp;
    logic [AW-1:0] cap_wr_base, cap_wr_len, cap_rd_base, cap_rd_len;
    logic cap_wr_fixed, cap_rd_fixed;

    // Master/memory model: drive inputs at negedge, sample handshakes 1ns later.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        write_control_done = 1'b0; write_user_buffer_full = 1'b0;
        read_control_done = 1'b0; read_user_data_available = 1'b0;
        read_user_buffer_output_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (wr_done_dly > 0) begin
                wr_done_dly--;
                if (wr_done_dly == 0) write_control_done = 1'b1;
            end
            write_user_buffer_full = (stall_left > 0) && (wr_pushes >= stall_at) && (wr_pushes < wr_words);
            if (write_user_buffer_full) begin stall_left--; full_cycles++; end
            if (rd_done_dly > 0) begin
                rd_done_dly--;
                if (rd_done_dly == 0) read_control_done = 1'b1;
            end
            read_user_data_available = (rd_fifo.size() > 0) && (!avail_toggle || (cyc % 2 == 0));
            read_user_buffer_output_data = (rd_fifo.size() > 0) ? rd_fifo[0] : '0;
            #1;
            if (pop_pending) begin
                n_checks++;
                if (last_read_data !== pop_exp) begin
                    n_errors++;
                    $display("FAIL last_read_data: got %h expected %h", last_read_data, pop_exp);
                end
                pop_pending = 1'b0;
            end
            if (write_user_buffer_full) begin
                n_checks++;
                if (write_user_write_buffer !== 1'b0) begin
                    n_errors++;
                    $display("FAIL push_while_full: got %b expected 0", write_user_write_buffer);
                end
            end
            if (write_control_go) begin
                wr_go_cnt++;
                cap_wr_base = write_control_write_base;
                cap_wr_len = write_control_write_length;
                cap_wr_fixed = write_control_fixed_location;
                wr_words = int'(cap_wr_len) >> 2;
                wr_pushes = 0; wr_done_dly = 0; write_control_done = 1'b0;
            end
            if (write_user_write_buffer && !write_user_buffer_full) begin
                mem[((int'(cap_wr_base) >> 2) + wr_pushes) & 1023] = write_user_buffer_data;
                n_checks++;
                if (exp_wr_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_push: got %h expected no push", write_user_buffer_data);
                end else begin
                    pop_exp = exp_wr_q.pop_front();
                    if (write_user_buffer_data !== pop_exp) begin
                        n_errors++;
                        $display("FAIL push_data: got %h expected %h", write_user_buffer_data, pop_exp);
                    end
                end
                push_cnt++; wr_pushes++;
                if (wr_pushes == wr_words) wr_done_dly = 3;
            end
            if (read_control_go) begin
                rd_go_cnt++;
                cap_rd_base = read_control_read_base;
                cap_rd_len = read_control_read_length;
                cap_rd_fixed = read_control_fixed_location;
                rd_fifo.delete();
                for (int i = 0; i < (int'(cap_rd_len) >> 2); i++) begin
                    pop_exp = mem[((int'(cap_rd_base) >> 2) + i) & 1023];
                    if (i == corrupt_pos) pop_exp = pop_exp ^ 32'h1;
                    rd_fifo.push_back(pop_exp);
                end
                read_control_done = 1'b0; rd_done_dly = 3;
            end
            if (read_user_read_buffer) begin
                n_checks++;
                if (!read_user_data_available || exp_rd_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL bad_pop: got pop avail=%b expected=%0d", read_user_data_available, exp_rd_q.size());
                end else begin
                    void'(rd_fifo.pop_front());
                    pop_exp = exp_rd_q.pop_front();
                    pop_pending = 1'b1;
                    pop_cnt++;
                end
            end
            if (done) begin
                done_cnt++;
                n_checks++;
                if (busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL busy_at_done: got %b expected 0", busy);
                end
            end
        end
    end

    task automatic start_cmd(input logic [1:0] m, input logic [AW-1:0] b, input logic [LW-1:0] n,
                             input logic [31:0] s, input logic fx);
        @(negedge clk);
        mode = m; base_address = b; num_words = n; seed = s; fixed_loc = fx; start = 1'b1;
        if (m != 2'd1)
            for (int i = 0; i < int'(n); i++) exp_wr_q.push_back(s + 32'(i));
        if (m == 2'd1)
            for (int i = 0; i < int'(n); i++) exp_rd_q.push_back(mem[((int'(b) >> 2) + i) & 1023]);
        else if (m != 2'd0)
            for (int i = 0; i < int'(n); i++)
                exp_rd_q.push_back((s + 32'(i)) ^ ((i == corrupt_pos) ? 32'h1 : 32'h0));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output int used, output bit ok);
        ok = 1'b0; used = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            used++;
            if (done_cnt != d0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        n_checks++; if (error_count !== '0) begin n_errors++; $display("FAIL reset_errcnt: got %h expected 0", error_count); end
        n_checks++; if (first_err_addr !== '0) begin n_errors++; $display("FAIL reset_first_err: got %h expected 0", first_err_addr); end
        n_checks++; if (last_read_data !== 32'hFEEDFEED) begin n_errors++; $display("FAIL reset_last_read: got %h expected feedfeed", last_read_data); end
        n_checks++;
        if ({write_control_go, read_control_go, write_user_write_buffer, read_user_read_buffer} !== 4'b0) begin
            n_errors++; $display("FAIL reset_strobes: got %b expected 0000",
                {write_control_go, read_control_go, write_user_write_buffer, read_user_read_buffer});
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_verify(input int cpos, input logic [AW-1:0] exp_first);
        int d0, used, w0, r0, p0, q0;
        bit ok;
        corrupt_pos = cpos;
        d0 = done_cnt; w0 = wr_go_cnt; r0 = rd_go_cnt; p0 = push_cnt; q0 = pop_cnt;
        start_cmd(2'd2, 26'h100, 16'd8, 32'hDEADBEEF, 1'b0);
        wait_done(d0, 300, used, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL verify_timeout: got no done expected done"); end
        n_checks++; if (wr_go_cnt - w0 != 1 || rd_go_cnt - r0 != 1) begin n_errors++; $display("FAIL verify_gos: got %0d/%0d expected 1/1", wr_go_cnt - w0, rd_go_cnt - r0); end
        n_checks++; if (cap_wr_len !== 26'd32 || cap_rd_len !== 26'd32) begin n_errors++; $display("FAIL verify_len: got %h/%h expected 20", cap_wr_len, cap_rd_len); end
        n_checks++; if (cap_wr_base !== 26'h100 || cap_rd_base !== 26'h100 || cap_wr_fixed !== 1'b0) begin n_errors++; $display("FAIL verify_base: got %h/%h expected 100", cap_wr_base, cap_rd_base); end
        n_checks++; if (push_cnt - p0 != 8 || pop_cnt - q0 != 8) begin n_errors++; $display("FAIL verify_counts: got %0d/%0d expected 8/8", push_cnt - p0, pop_cnt - q0); end
        n_checks++; if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin n_errors++; $display("FAIL verify_queues: got %0d/%0d expected 0/0", exp_wr_q.size(), exp_rd_q.size()); end
        n_checks++; if (error_count !== ((cpos < 0) ? 16'd0 : 16'd1)) begin n_errors++; $display("FAIL verify_errcnt: got %0d expected %0d", error_count, (cpos < 0) ? 0 : 1); end
        if (cpos >= 0) begin
            n_checks++; if (first_err_addr !== exp_first) begin n_errors++; $display("FAIL verify_first_err: got %h expected %h", first_err_addr, exp_first); end
        end
        repeat (4) @(negedge clk);
        #2;
        n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL verify_done_pulses: got %0d expected 1", done_cnt - d0); end
        corrupt_pos = -1;
    endtask

    task automatic test_zero_len;
        int d0, used, w0, r0;
        bit ok;
        d0 = done_cnt; w0 = wr_go_cnt; r0 = rd_go_cnt;
        start_cmd(2'd2, 26'h103, 16'd0, 32'h0, 1'b0);
        wait_done(d0, 10, used, ok);
        n_checks++; if (!ok || used > 2) begin n_errors++; $display("FAIL zero_len_done: got ok=%b after %0d expected within 2", ok, used); end
        n_checks++; if (wr_go_cnt != w0 || rd_go_cnt != r0) begin n_errors++; $display("FAIL zero_len_gos: got %0d/%0d expected 0/0", wr_go_cnt - w0, rd_go_cnt - r0); end
        n_checks++; if (error_count !== '0) begin n_errors++; $display("FAIL zero_len_errcnt: got %0d expected 0", error_count); end
        n_checks++; if (write_control_write_base !== 26'h100) begin n_errors++; $display("FAIL zero_len_base: got %h expected 100", write_control_write_base); end
    endtask

    task automatic test_full_stall;
        int d0, used, p0, r0, f0;
        bit ok;
        stall_at = 3; stall_left = 10; f0 = full_cycles;
        d0 = done_cnt; p0 = push_cnt; r0 = rd_go_cnt;
        start_cmd(2'd0, 26'h203, 16'd8, 32'h12345678, 1'b1);
        wait_done(d0, 300, used, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL stall_timeout: got no done expected done"); end
        n_checks++; if (full_cycles - f0 != 10) begin n_errors++; $display("FAIL stall_full_cycles: got %0d expected 10", full_cycles - f0); end
        n_checks++; if (push_cnt - p0 != 8 || exp_wr_q.size() != 0) begin n_errors++; $display("FAIL stall_pushes: got %0d expected 8", push_cnt - p0); end
        n_checks++; if (rd_go_cnt != r0) begin n_errors++; $display("FAIL stall_read_go: got %0d expected 0", rd_go_cnt - r0); end
        n_checks++; if (cap_wr_base !== 26'h200 || cap_wr_fixed !== 1'b1) begin n_errors++; $display("FAIL stall_base: got %h/%b expected 200/1", cap_wr_base, cap_wr_fixed); end
        stall_left = 0;
    endtask

    task automatic test_read_only;
        int d0, used, q0, w0;
        bit ok;
        logic [31:0] w3;
        for (int i = 0; i < 4; i++) mem[(26'h300 >> 2) + i] = $urandom | 32'h100;
        w3 = mem[(26'h300 >> 2) + 3];
        avail_toggle = 1'b1;
        d0 = done_cnt; q0 = pop_cnt; w0 = wr_go_cnt;
        start_cmd(2'd1, 26'h300, 16'd4, 32'h0, 1'b0);
        wait_done(d0, 300, used, ok);
        #0;
        n_checks++; if (!ok) begin n_errors++; $display("FAIL rdonly_timeout: got no done expected done"); end
        n_checks++; if (pop_cnt - q0 != 4 || exp_rd_q.size() != 0) begin n_errors++; $display("FAIL rdonly_pops: got %0d expected 4", pop_cnt - q0); end
        n_checks++; if (wr_go_cnt != w0) begin n_errors++; $display("FAIL rdonly_write_go: got %0d expected 0", wr_go_cnt - w0); end
        n_checks++; if (last_read_data !== w3) begin n_errors++; $display("FAIL rdonly_last: got %h expected %h", last_read_data, w3); end
        n_checks++; if (error_count !== '0) begin n_errors++; $display("FAIL rdonly_errcnt: got %0d expected 0", error_count); end
        avail_toggle = 1'b0;
    endtask

    task automatic test_reset_mid;
        int d0, used, p0, p1, q0;
        bit ok;
        p0 = push_cnt;
        start_cmd(2'd2, 26'h400, 16'd8, 32'hA5A50000, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            if (push_cnt - p0 >= 3) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) begin n_errors++; $display("FAIL midrst_pushes_timeout: got %0d expected 3", push_cnt - p0); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        #2;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b%b expected 00", busy, done); end
        n_checks++;
        if ({write_control_go, read_control_go, write_user_write_buffer, read_user_read_buffer} !== 4'b0) begin
            n_errors++; $display("FAIL midrst_strobes: got %b expected 0000",
                {write_control_go, read_control_go, write_user_write_buffer, read_user_read_buffer});
        end
        n_checks++; if (error_count !== '0 || last_read_data !== 32'hFEEDFEED) begin n_errors++; $display("FAIL midrst_status: got %h/%h expected 0/feedfeed", error_count, last_read_data); end
        p1 = push_cnt;
        repeat (5) @(negedge clk);
        #2;
        n_checks++; if (push_cnt != p1) begin n_errors++; $display("FAIL midrst_quiet: got %0d pushes expected 0", push_cnt - p1); end
        exp_wr_q.delete(); exp_rd_q.delete();
        d0 = done_cnt; p0 = push_cnt; q0 = pop_cnt;
        start_cmd(2'd3, 26'h500, 16'd4, 32'hFFFFFFFE, 1'b1);
        wait_done(d0, 300, used, ok);
        n_checks++; if (!ok || push_cnt - p0 != 4 || pop_cnt - q0 != 4) begin n_errors++; $display("FAIL midrst_rerun: got ok=%b %0d/%0d expected 4/4", ok, push_cnt - p0, pop_cnt - q0); end
        n_checks++; if (error_count !== '0 || last_read_data !== 32'h00000001) begin n_errors++; $display("FAIL midrst_rerun_status: got %0d/%h expected 0/00000001", error_count, last_read_data); end
        n_checks++; if (cap_rd_fixed !== 1'b1) begin n_errors++; $display("FAIL midrst_fixed: got %b expected 1", cap_rd_fixed); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 2'd0; fixed_loc = 1'b0;
        base_address = '0; num_words = '0; seed = '0;
        test_reset;
        test_verify(-1, 26'h0);
        test_verify(5, 26'h114);
        test_zero_len;
        test_full_stall;
        test_read_only;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
